// File: rtl/pid_scheduler.sv
// Time-multiplexes one PID controller across NUMBER_OF_MOTORS muscles: on every
// control tick it sweeps the enabled motors, strobes the PID and latches its PWM.
module pid_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int TICK_DIVIDER     = 50000,
  parameter int SETTLE_CYCLES    = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUMBER_OF_MOTORS-1:0]     motor_enable,
  input  logic signed [15:0]              pid_pwm,
  input  logic                            overrun_clear,
  output logic [7:0]                      pid_motor_select,
  output logic                            pid_update,
  output logic [16*NUMBER_OF_MOTORS-1:0]  pwm_out,
  output logic [NUMBER_OF_MOTORS-1:0]     pwm_valid,
  output logic                            cycle_done,
  output logic                            overrun
);

  localparam int CW = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam int WW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, SETUP, TRIGGER, WAIT, CAPTURE, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        tick_counter;
  logic                 tick;
  logic [WW-1:0]        settle_count;
  logic [7:0]           idx;
  logic                 motor_sel_en;
  logic signed [15:0]   pwm_reg [NUMBER_OF_MOTORS];

  assign tick = (tick_counter == CW'(TICK_DIVIDER - 1));

  always_comb begin
    motor_sel_en = 1'b0;
    for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
      if (idx == 8'(i)) motor_sel_en = motor_enable[i];
    end
  end

  for (genvar g = 0; g < NUMBER_OF_MOTORS; g++) begin : g_pwm
    assign pwm_out[16*g +: 16] = pwm_reg[g];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      tick_counter     <= '0;
      settle_count     <= '0;
      idx              <= '0;
      pid_motor_select <= '0;
      pid_update       <= 1'b0;
      pwm_valid        <= '0;
      cycle_done       <= 1'b0;
      overrun          <= 1'b0;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) pwm_reg[i] <= '0;
    end else begin
      tick_counter <= tick ? '0 : tick_counter + 1'b1;
      pwm_valid    <= '0;
      cycle_done   <= 1'b0;

      // A tick landing mid-sweep is dropped; flagging it beats a pending clear.
      if (tick && state != IDLE)  overrun <= 1'b1;
      else if (overrun_clear)     overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (tick && enable) begin
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == 8'(NUMBER_OF_MOTORS)) begin
            cycle_done <= 1'b1;
            state      <= DONE;
          end else if (motor_sel_en) begin
            pid_motor_select <= idx;
            state            <= SETUP;
          end else begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
              if (idx == 8'(i)) pwm_reg[i] <= '0;
            end
            idx <= idx + 8'd1;
          end
        end
        SETUP: begin
          pid_update <= 1'b1;
          state      <= TRIGGER;
        end
        TRIGGER: begin
          settle_count <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (settle_count == WW'(SETTLE_CYCLES - 1)) begin
            pid_update <= 1'b0;
            state      <= CAPTURE;
          end else begin
            settle_count <= settle_count + 1'b1;
          end
        end
        CAPTURE: begin
          // Data and its valid strobe become visible on the same edge.
          for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            if (idx == 8'(i)) begin
              pwm_reg[i]   <= pid_pwm;
              pwm_valid[i] <= 1'b1;
            end
          end
          idx   <= idx + 8'd1;
          state <= SCAN;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_scheduler.sv
// Bench for pid_scheduler: instance 0 ticks every 40 cycles, instance 1 every 20
// (so a full sweep overruns). Four motors, two settle cycles.
module tb_pid_scheduler;
  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst [2];
  logic               en  [2];
  logic               clr [2];
  logic [3:0]         me  [2];
  logic signed [15:0] pid [2];
  logic [7:0]         sel [2];
  logic               pu  [2];
  logic [63:0]        pwm [2];
  logic [3:0]         vld [2];
  logic               cd  [2];
  logic               ov  [2];
  int                 base [2];
  int                 mult [2];

  // PID stand-in: output is a linear function of the selected motor index.
  assign pid[0] = 16'(base[0] + mult[0] * int'(sel[0]));
  assign pid[1] = 16'(base[1] + mult[1] * int'(sel[1]));

  pid_scheduler #(.NUMBER_OF_MOTORS(N), .TICK_DIVIDER(40), .SETTLE_CYCLES(S)) dut_a (
    .clock(clk), .reset(rst[0]), .enable(en[0]), .motor_enable(me[0]), .pid_pwm(pid[0]),
    .overrun_clear(clr[0]), .pid_motor_select(sel[0]), .pid_update(pu[0]), .pwm_out(pwm[0]),
    .pwm_valid(vld[0]), .cycle_done(cd[0]), .overrun(ov[0]));

  pid_scheduler #(.NUMBER_OF_MOTORS(N), .TICK_DIVIDER(20), .SETTLE_CYCLES(S)) dut_b (
    .clock(clk), .reset(rst[1]), .enable(en[1]), .motor_enable(me[1]), .pid_pwm(pid[1]),
    .overrun_clear(clr[1]), .pid_motor_select(sel[1]), .pid_update(pu[1]), .pwm_out(pwm[1]),
    .pwm_valid(vld[1]), .cycle_done(cd[1]), .overrun(ov[1]));

  int tests = 0;
  int failed = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int td(input int d);
    return (d == 0) ? 40 : 20;
  endfunction

  function automatic int slice(input int d, input int i);
    logic signed [15:0] s;
    s = pwm[d][16*i +: 16];
    return int'(s);
  endfunction

  // Reference tick counter, independent of the DUT.
  int mcnt [2] = '{0, 0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      mcnt[d] <= rst[d] ? 0 : ((mcnt[d] == td(d) - 1) ? 0 : mcnt[d] + 1);
  end

  // Cycle monitor: sweep start/latency, strobe counts, pulse widths, valid data.
  int cyc = 0;
  bit busy [2] = '{0, 0};
  bit pu_prev [2] = '{0, 0};
  bit rst_q [2] = '{0, 0};
  int start [2] = '{0, 0};
  int lat [2] = '{0, 0};
  int ndone [2] = '{0, 0};
  int nupd [2] = '{0, 0};
  int nvld [2] = '{0, 0};
  int plen [2] = '{0, 0};
  int badlen [2] = '{0, 0};
  logic signed [15:0] mon_e;

  always @(negedge clk) begin
    #2;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) busy[d] = 1'b0;
      else if (mcnt[d] == td(d) - 1 && !busy[d] && en[d]) begin
        busy[d] = 1'b1;
        start[d] = cyc;
      end
      if (cd[d]) begin
        ndone[d]++;
        lat[d] = cyc - start[d];
        busy[d] = 1'b0;
      end
      if (pu[d]) begin
        if (!pu_prev[d]) begin
          nupd[d]++;
          plen[d] = 0;
        end
        plen[d]++;
      end else if (pu_prev[d] && !rst_q[d] && plen[d] != S + 1) begin
        badlen[d]++;
      end
      for (int i = 0; i < N; i++) begin
        if (vld[d][i]) begin
          nvld[d]++;
          mon_e = 16'(base[d] + mult[d] * i);
          check($sformatf("valid_data_d%0d_m%0d", d, i), slice(d, i), int'(mon_e));
        end
      end
      pu_prev[d] = pu[d];
      rst_q[d] = rst[d];
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input int d);
    int n = 0;
    while (!busy[d] && n < 100) begin step(); n++; end
    if (!busy[d]) check($sformatf("start_timeout_d%0d", d), 0, 1);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!cd[d] && n < 200) begin step(); n++; end
    if (!cd[d]) check($sformatf("done_timeout_d%0d", d), 0, 1);
    else step();
  endtask

  typedef struct {
    logic [3:0]        me;
    int                base;
    int                mult;
    logic [3:0][15:0]  exp;
    int                upd;
    int                lat;
  } vec_t;

  vec_t vec [6];

  initial begin
    int u0, v0, dn0, n;
    logic [63:0] snap;

    // Sweep latency tick->cycle_done = 6 per enabled + 1 per disabled + 2.
    vec[0] = '{4'b1111,    100,  1, {16'sd103, 16'sd102, 16'sd101, 16'sd100}, 4, 26};
    vec[1] = '{4'b0101,   -500,  0, {16'sd0, -16'sd500, 16'sd0, -16'sd500},  2, 16};
    vec[2] = '{4'b1010, -32768,  1, {-16'sd32765, 16'sd0, -16'sd32767, 16'sd0}, 2, 16};
    vec[3] = '{4'b0000,      7,  0, {16'sd0, 16'sd0, 16'sd0, 16'sd0},         0, 6};
    vec[4] = '{4'b1000,  32767,  0, {16'sd32767, 16'sd0, 16'sd0, 16'sd0},     1, 11};
    vec[5] = '{4'b0110,      0, -1, {16'sd0, -16'sd2, -16'sd1, 16'sd0},       2, 16};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; clr[d] = 1'b0; me[d] = 4'b0000;
      base[d] = 0; mult[d] = 0;
    end
    step(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    check("reset_pid_update", pu[0], 0);
    check("reset_select", sel[0], 0);
    check("reset_pwm_out", pwm[0], 0);
    check("reset_valid", vld[0], 0);
    check("reset_cycle_done", cd[0], 0);
    check("reset_overrun", ov[0], 0);

    // Table-driven sweeps on the slow-tick instance.
    for (int k = 0; k < 6; k++) begin
      u0 = nupd[0]; v0 = nvld[0]; dn0 = ndone[0];
      me[0] = vec[k].me; base[0] = vec[k].base; mult[0] = vec[k].mult;
      en[0] = 1'b1;
      wait_busy(0);
      en[0] = 1'b0;
      wait_done(0);
      check($sformatf("v%0d_latency", k), lat[0], vec[k].lat);
      check($sformatf("v%0d_updates", k), nupd[0] - u0, vec[k].upd);
      check($sformatf("v%0d_valids", k), nvld[0] - v0, vec[k].upd);
      check($sformatf("v%0d_dones", k), ndone[0] - dn0, 1);
      check($sformatf("v%0d_overrun", k), ov[0], 0);
      for (int i = 0; i < N; i++)
        check($sformatf("v%0d_slice%0d", k, i), slice(0, i), int'($signed(vec[k].exp[i])));
    end

    // enable held low across three ticks: nothing moves.
    snap = pwm[0]; u0 = nupd[0]; dn0 = ndone[0];
    step(125);
    check("idle_updates", nupd[0] - u0, 0);
    check("idle_dones", ndone[0] - dn0, 0);
    check("idle_pwm", pwm[0], snap);

    // Reset while waiting on the PID aborts cleanly.
    me[0] = 4'b1111; base[0] = 100; mult[0] = 1;
    en[0] = 1'b1;
    n = 0;
    while (!pu[0] && n < 100) begin step(); n++; end
    check("abort_trigger_seen", pu[0], 1);
    en[0] = 1'b0;
    step();
    check("abort_in_wait", pu[0], 1);
    dn0 = ndone[0]; v0 = nvld[0];
    rst[0] = 1'b1;
    step();
    check("abort_pid_update", pu[0], 0);
    check("abort_pwm_out", pwm[0], 0);
    check("abort_select", sel[0], 0);
    check("abort_valid", vld[0], 0);
    check("abort_cycle_done", cd[0], 0);
    rst[0] = 1'b0;
    en[0] = 1'b1;
    // First tick is 40 cycles after release; pid_update follows 3 cycles later.
    n = 0;
    while (!pu[0] && n < 100) begin step(); n++; end
    check("first_tick_after_reset", n, 42);
    check("abort_no_done", ndone[0] - dn0, 0);
    check("abort_no_capture", nvld[0] - v0, 0);
    en[0] = 1'b0;
    wait_done(0);
    check("post_reset_latency", lat[0], 26);

    // Fast-tick instance: sweep spans the next tick.
    me[1] = 4'b1111; base[1] = 100; mult[1] = 1;
    u0 = nupd[1]; dn0 = ndone[1];
    en[1] = 1'b1;
    wait_busy(1);
    check("ovr_before_tick", ov[1], 0);
    n = 0;
    while (mcnt[1] != 19 && n < 40) begin step(); n++; end
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check("ovr_set_beats_clear", ov[1], 1);
    wait_done(1);
    en[1] = 1'b0;
    check("ovr_latency", lat[1], 26);
    check("ovr_updates", nupd[1] - u0, 4);
    check("ovr_dones", ndone[1] - dn0, 1);
    for (int i = 0; i < N; i++)
      check($sformatf("ovr_slice%0d", i), slice(1, i), 100 + i);
    step(3);
    check("ovr_sticky", ov[1], 1);
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check("ovr_cleared", ov[1], 0);

    check("pulse_len_errors", badlen[0] + badlen[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 6: number of muscles sharing one PID controller instance (1..255).
REQ-002 SHALL have parameter TICK_DIVIDER, default 50000: clock cycles per control tick (1 kHz at 50 MHz); minimum 2.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2: cycles pid_update is held high after the trigger cycle, before capture; minimum 1.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  permits a sweep to start on a tick.
REQ-007 SHALL have port motor_enable  in  NUMBER_OF_MOTORS  per-motor enable; bit i = motor i.
REQ-008 SHALL have port pid_pwm  in  16 signed  pwmRef returned by the shared PID controller.
REQ-009 SHALL have port overrun_clear  in  1  clears overrun.
REQ-010 SHALL have port pid_motor_select  out  8  motor index steering the parameter/feedback mux into the shared PID.
REQ-011 SHALL have port pid_update  out  1  update_controller strobe to the shared PID; the PID acts on its rising edge.
REQ-012 SHALL have port pwm_out  out  16*NUMBER_OF_MOTORS  per-motor latched PWM; motor i occupies bits [16i+15:16i].
REQ-013 SHALL have port pwm_valid  out  NUMBER_OF_MOTORS  one-cycle strobe per motor when its pwm_out slice updates.
REQ-014 SHALL have port cycle_done  out  1  one-cycle pulse at sweep end.
REQ-015 SHALL have port overrun  out  1  sticky: a tick arrived while a sweep was in progress.

Function
REQ-016 SHALL count tick_counter 0..TICK_DIVIDER-1, free-running regardless of enable, and assert an internal tick in the cycle tick_counter = TICK_DIVIDER-1.
REQ-017 SHALL implement states IDLE, SCAN, SETUP, TRIGGER, WAIT, CAPTURE, DONE; each occupies at least one cycle.
REQ-018 IDLE: on tick with enable=1, set idx=0 and go to SCAN; otherwise stay in IDLE.
REQ-019 SCAN: if idx = NUMBER_OF_MOTORS, go to DONE; else if motor_enable[idx]=1, go to SETUP; else force pwm_out slice idx to 0, increment idx, and stay in SCAN.
REQ-020 SETUP: drive pid_motor_select = idx, held until the next SETUP; go to TRIGGER.
REQ-021 pid_update SHALL be a flop output, set on entry to TRIGGER and cleared on entry to CAPTURE, so it is high for exactly 1+SETTLE_CYCLES cycles.
REQ-022 WAIT: count SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-023 CAPTURE: latch pid_pwm into pwm_out slice idx, pulse pwm_valid[idx] for that cycle, increment idx, and go to SCAN.
REQ-024 DONE: pulse cycle_done for one cycle; go to IDLE.
REQ-025 Sweep length SHALL be (SETTLE_CYCLES+4) per enabled motor + 1 per disabled motor + 2 cycles, from the tick cycle to the cycle_done cycle inclusive.
REQ-026 A tick outside IDLE SHALL be dropped and SHALL set overrun; the running sweep is unaffected.
REQ-027 overrun_clear SHALL clear overrun; if set and clear occur in the same cycle, set wins.
REQ-028 enable and motor_enable SHALL be sampled only in IDLE and SCAN respectively; deasserting them mid-motor does not abort that motor.
REQ-029 pid_pwm SHALL be passed to pwm_out without sign or width change.

Reset
REQ-030 reset=1 SHALL, at the next edge, force IDLE, idx=0, tick_counter=0, pid_motor_select=0, pid_update=0, pwm_out all 0, pwm_valid=0, cycle_done=0, overrun=0, regardless of state.
REQ-031 After reset is released, the first tick SHALL occur TICK_DIVIDER cycles later.

Verification (NUMBER_OF_MOTORS=4, SETTLE_CYCLES=2 unless stated)
REQ-032 TICK_DIVIDER=40, motor_enable=4'b1111, pid_pwm = 100+pid_motor_select -> pwm_out = {103,102,101,100}, 4 pwm_valid pulses, cycle_done 26 cycles after tick, each pid_update high 3 cycles, overrun=0.
REQ-033 TICK_DIVIDER=40, motor_enable=4'b0101, pid_pwm=-500 -> slices 0 and 2 = -500, slices 1 and 3 = 0, only 2 pid_update pulses, cycle_done 16 cycles after tick.
REQ-034 TICK_DIVIDER=20, all motors enabled -> 26-cycle sweep spans the next tick; overrun=1, second tick ignored, sweep completes normally.
REQ-035 overrun=1, overrun_clear=1 in the same cycle as a new overrun -> overrun stays 1; overrun_clear alone in a later cycle -> 0.
REQ-036 Reset asserted in WAIT with pid_update=1 -> next cycle pid_update=0, pwm_out=0, IDLE; no capture or cycle_done pulse.
REQ-037 enable=0 across 3 ticks -> pid_update stays 0 and pwm_out unchanged.
